// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_pkg
// Brief    : Note dividers, song ROM word layout and sequencer state encoding.
// Revision : 1.0
// ============================================================================
package music_pkg;

    localparam logic [15:0] c_note_c4  = 16'd45977;
    localparam logic [15:0] c_note_d4  = 16'd40955;
    localparam logic [15:0] c_note_e4  = 16'd36474;
    localparam logic [15:0] c_note_f4  = 16'd34383;
    localparam logic [15:0] c_note_g4  = 16'd30612;
    localparam logic [15:0] c_note_a4  = 16'd27272;
    localparam logic [15:0] c_note_as4 = 16'd25751;
    localparam logic [15:0] c_note_c5  = 16'd22944;

    localparam int c_rom_w   = 20;
    localparam int c_dur_msb = 19;
    localparam int c_dur_lsb = 16;
    localparam int c_div_msb = 15;
    localparam int c_div_lsb = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/song_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer_if
// Brief    : Control, song ROM and tone generator signals of the sequencer.
// Revision : 1.0
// ============================================================================
interface song_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [19:0]       rom_data;
    logic [15:0]       tone_div;
    logic              tone_en;
    logic              busy;
    logic              done;

    // master: the sequencer itself; slave: controller, ROM and tone generator
    modport master (
        input  start, stop, rom_data,
        output rom_addr, tone_div, tone_en, busy, done
    );

    modport slave (
        output start, stop, rom_data,
        input  rom_addr, tone_div, tone_en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/song_sequencer_beat_timer.sv
`default_nettype none
// ============================================================================
// Module   : beat_timer
// Brief    : Loadable down-counter timing both the sounding and gap intervals.
// Revision : 1.0
// ============================================================================
module beat_timer #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;
    logic             r_zero;

    // zero is high in the cycle whose decrement brings the count to 0, so the
    // controller leaves a state of N cycles on exactly its N-th edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_zero  <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_zero  <= (load_val == WIDTH'(1));
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
            r_zero  <= (r_count == WIDTH'(2));
        end
    end

    assign zero = r_zero;

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer
// Brief    : Steps song ROM notes, drives tone divider/enable with gaps.
// Revision : 1.0
// ============================================================================
module song_sequencer
    import music_pkg::*;
#(
    parameter int BEAT_CYCLES = 3000000,
    parameter int GAP_CYCLES  = 120000,
    parameter int SONG_LEN    = 26,
    parameter int ADDR_W      = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    song_sequencer_if.master  bus
);

    localparam logic [31:0]       c_beat      = 32'(BEAT_CYCLES);
    localparam logic [31:0]       c_gap       = 32'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(SONG_LEN - 1);

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_rom_addr, w_addr_nxt;
    logic [15:0]       r_tone_div, w_div_nxt;
    logic              r_tone_en, w_en_nxt;
    logic              w_load, w_dec, w_zero;
    logic [31:0]       w_load_val;
    logic [3:0]        w_dur;
    logic [15:0]       w_div;
    logic [31:0]       w_play_len;

    assign w_dur      = bus.rom_data[c_dur_msb:c_dur_lsb];
    assign w_div      = bus.rom_data[c_div_msb:c_div_lsb];
    assign w_play_len = (32'(w_dur) * c_beat) - c_gap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
            r_tone_div <= '0;
            r_tone_en  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rom_addr <= w_addr_nxt;
            r_tone_div <= w_div_nxt;
            r_tone_en  <= w_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_rom_addr;
        w_div_nxt   = r_tone_div;
        w_en_nxt    = r_tone_en;
        w_load      = 1'b0;
        w_load_val  = w_play_len;
        w_dec       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_state_nxt = ST_FETCH;
                    w_addr_nxt  = '0;
                end
            end
            ST_FETCH: w_state_nxt = ST_LATCH;
            ST_LATCH: begin
                if (w_dur == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_load      = 1'b1;
                    w_div_nxt   = w_div;
                    w_en_nxt    = (w_div != 16'd0);
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    w_en_nxt    = 1'b0;
                    w_load      = 1'b1;
                    w_load_val  = c_gap;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    if (r_rom_addr == c_last_addr) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_addr_nxt  = r_rom_addr + ADDR_W'(1);
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                w_addr_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // an abort overrides whatever the active state decided
        if (bus.stop && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_en_nxt    = 1'b0;
            w_addr_nxt  = '0;
            w_load      = 1'b0;
            w_dec       = 1'b0;
        end
    end

    beat_timer #(
        .WIDTH (32)
    ) u_beat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    assign bus.rom_addr = r_rom_addr;
    assign bus.tone_div = r_tone_div;
    assign bus.tone_en  = r_tone_en;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);

endmodule
`default_nettype wire
